// File: rtl/test_harness_pkg.sv
// Shared definitions for the UART-controlled pulse test harness.
// Holds the packet layout (40-bit message, header byte, 32-bit payload),
// the header codes, the parameter field positions inside the payload and
// the state encodings used by the receiver and the pulse state machine.
package test_harness_pkg;

  // Packet layout: byte 0 is the header, bytes 1..4 are the payload.
  localparam int MSG_W   = 40;
  localparam int HDR_LSB = 0;
  localparam int HDR_W   = 8;
  localparam int PAY_LSB = 8;
  localparam int PAY_W   = 32;

  // One UART frame per byte: start + 8 data + stop.
  localparam int FRAME_BITS = 10;
  localparam int RESP_BYTES = MSG_W / 8;
  localparam int FRAME_W    = FRAME_BITS * RESP_BYTES;

  localparam logic [7:0] HDR_MEM_PARAMS = 8'h01;
  localparam logic [7:0] HDR_SYS_STATUS = 8'h02;
  localparam logic [7:0] HDR_DONE       = 8'h03;

  // Field positions inside the payload.
  localparam int P_NO_NUMS_LSB = 0;
  localparam int P_TEST_MODE   = 8;
  localparam int P_WIDTH_LSB   = 16;
  localparam int P_GAP_LSB     = 24;
  localparam int P_RUN_BIT     = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_GAP, ST_REPORT} run_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // A programmed width/gap of zero behaves as one cycle.
  function automatic logic [7:0] at_least_one(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/test_harness_if.sv
// Received-byte stream between the UART receiver and the packet assembler.
//   byte_valid : one-cycle strobe, byte_data holds a byte with a good stop bit
//   byte_data  : received byte (valid with byte_valid)
//   frame_err  : one-cycle strobe, a byte ended with its stop bit sampled low
interface test_harness_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  modport master (output byte_valid, byte_data, frame_err);
  modport slave  (input  byte_valid, byte_data, frame_err);
endinterface

// File: rtl/test_harness_uart_rx.sv
// 8N1 UART receiver.
//   clk, rst  : clock and synchronous active-high reset
//   i_rx_pin  : asynchronous serial input, idle high
//   rx_bus    : byte stream out (byte_valid / byte_data / frame_err strobes)
// The line is double-flopped, a falling edge arms the receiver, the start bit
// is re-checked at its centre and every following bit is sampled at its centre.
module uart_rx
  import test_harness_pkg::*;
#(
  parameter int CLKS_PER_BAUD = 1250
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_rx_pin,
  test_harness_if.master rx_bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BAUD);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BAUD - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BAUD / 2 - 1);

  logic             r_sync1, r_sync2, r_prev;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid, r_frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_prev       <= 1'b1;
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync1      <= i_rx_pin;
      r_sync2      <= r_sync1;
      r_prev       <= r_sync2;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_prev && !r_sync2) begin
            r_state <= RX_START;
            r_cnt   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (r_cnt == '0) begin
            // A glitch that is high again at mid-bit is not a start bit.
            if (!r_sync2) begin
              r_state   <= RX_DATA;
              r_cnt     <= BIT_LAST;
              r_bit_idx <= '0;
            end else begin
              r_state <= RX_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == '0) begin
            r_shift   <= {r_sync2, r_shift[7:1]};   // LSB arrives first
            r_cnt     <= BIT_LAST;
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == '0) begin
            r_byte_valid <= r_sync2;
            r_frame_err  <= !r_sync2;
            r_state      <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_bus.byte_valid = r_byte_valid;
  assign rx_bus.byte_data  = r_shift;
  assign rx_bus.frame_err  = r_frame_err;
endmodule

// File: rtl/test_harness.sv
// UART-controlled pulse generator.
//   clk, rst     : clock and synchronous active-high reset
//   uart_rx_pin  : command input (5-byte packets, LSB byte first)
//   uart_tx_pin  : response output (5-byte DONE packet with pulse count)
//   led0         : pulse train, pulse_width cycles high / pulse_gap cycles low
//   led1         : high while a run is active
// MEM_PARAMS loads the parameter registers, SYS_STATUS starts (bit0=1) or
// stops (bit0=0) a run. A run uses a snapshot of the parameters taken at start.
module test_harness
  import test_harness_pkg::*;
#(
  parameter int CLK_RATE = 12_000_000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_rx_pin,
  output logic uart_tx_pin,
  output logic led0,
  output logic led1
);
  localparam int CLKS_PER_BAUD = CLK_RATE / BAUD;
  localparam int CNT_W = $clog2(CLKS_PER_BAUD);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BAUD - 1);

  test_harness_if w_rx_bus ();

  uart_rx #(.CLKS_PER_BAUD(CLKS_PER_BAUD)) u_uart_rx (
    .clk     (clk),
    .rst     (rst),
    .i_rx_pin(uart_rx_pin),
    .rx_bus  (w_rx_bus)
  );

  // ---------------- packet assembler ----------------
  logic [MSG_W-1:0] r_msg;
  logic [2:0]       r_byte_cnt;
  logic [MSG_W-1:0] w_msg;
  logic             w_cmd_valid;
  logic [HDR_W-1:0] w_hdr;
  logic [PAY_W-1:0] w_pay;

  // The fifth byte is decoded straight off the receiver strobe, so the
  // command acts one cycle after its stop-bit sample.
  assign w_msg       = {w_rx_bus.byte_data, r_msg[MSG_W-1:8]};
  assign w_cmd_valid = w_rx_bus.byte_valid && (r_byte_cnt == 3'd4);
  assign w_hdr       = w_msg[HDR_LSB +: HDR_W];
  assign w_pay       = w_msg[PAY_LSB +: PAY_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_msg      <= '0;
      r_byte_cnt <= '0;
    end else if (w_rx_bus.frame_err) begin
      r_byte_cnt <= '0;
    end else if (w_rx_bus.byte_valid) begin
      r_msg      <= w_msg;
      r_byte_cnt <= (r_byte_cnt == 3'd4) ? 3'd0 : r_byte_cnt + 1'b1;
    end
  end

  // ---------------- parameter registers ----------------
  logic [7:0] r_no_nums, r_pulse_width, r_pulse_gap;
  logic       r_test_mode;
  logic       w_unused_pay;

  assign w_unused_pay = &{1'b0, w_pay[P_WIDTH_LSB-1:P_TEST_MODE+1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_no_nums     <= 8'd0;
      r_test_mode   <= 1'b0;
      r_pulse_width <= 8'd1;
      r_pulse_gap   <= 8'd1;
    end else if (w_cmd_valid && w_hdr == HDR_MEM_PARAMS) begin
      r_no_nums     <= w_pay[P_NO_NUMS_LSB +: 8];
      r_test_mode   <= w_pay[P_TEST_MODE];
      r_pulse_width <= w_pay[P_WIDTH_LSB +: 8];
      r_pulse_gap   <= w_pay[P_GAP_LSB +: 8];
    end
  end

  // ---------------- pulse state machine ----------------
  run_state_t  r_state;
  logic [7:0]  r_run_width, r_run_gap, r_run_nums, r_phase_cnt;
  logic        r_run_mode, r_stop_req, r_led0, r_led1;
  logic [31:0] r_pulses;
  logic        r_tx_busy;
  logic        w_start, w_stop, w_more;

  assign w_start = w_cmd_valid && (w_hdr == HDR_SYS_STATUS) && w_pay[P_RUN_BIT]
                   && (r_state == ST_IDLE) && !r_tx_busy;
  assign w_stop  = w_cmd_valid && (w_hdr == HDR_SYS_STATUS) && !w_pay[P_RUN_BIT];
  // A stop arriving on the last gap cycle still counts for this gap.
  assign w_more  = !(r_stop_req || w_stop) &&
                   (r_run_mode || (r_pulses < {24'd0, r_run_nums}));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_run_width <= 8'd1;
      r_run_gap   <= 8'd1;
      r_run_nums  <= 8'd0;
      r_run_mode  <= 1'b0;
      r_phase_cnt <= 8'd0;
      r_stop_req  <= 1'b0;
      r_pulses    <= '0;
      r_led0      <= 1'b0;
      r_led1      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_run_width <= at_least_one(r_pulse_width);
            r_run_gap   <= at_least_one(r_pulse_gap);
            r_run_nums  <= r_no_nums;
            r_run_mode  <= r_test_mode;
            r_pulses    <= '0;
            r_stop_req  <= 1'b0;
            if (!r_test_mode && r_no_nums == 8'd0) begin
              r_state <= ST_REPORT;
            end else begin
              r_state     <= ST_HIGH;
              r_led0      <= 1'b1;
              r_led1      <= 1'b1;
              r_phase_cnt <= at_least_one(r_pulse_width) - 8'd1;
            end
          end
        end
        ST_HIGH: begin
          if (w_stop) r_stop_req <= 1'b1;
          if (r_phase_cnt == 8'd0) begin
            r_state     <= ST_GAP;
            r_led0      <= 1'b0;
            r_phase_cnt <= r_run_gap - 8'd1;
            r_pulses    <= r_pulses + 32'd1;
          end else begin
            r_phase_cnt <= r_phase_cnt - 8'd1;
          end
        end
        ST_GAP: begin
          if (w_stop) r_stop_req <= 1'b1;
          if (r_phase_cnt == 8'd0) begin
            if (w_more) begin
              r_state     <= ST_HIGH;
              r_led0      <= 1'b1;
              r_phase_cnt <= r_run_width - 8'd1;
            end else begin
              r_state <= ST_REPORT;
              r_led1  <= 1'b0;
            end
          end else begin
            r_phase_cnt <= r_phase_cnt - 8'd1;
          end
        end
        ST_REPORT: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- response transmitter ----------------
  // The whole DONE packet is laid out as one 50-bit serial frame so the
  // bytes leave back-to-back with no idle time between them.
  logic [MSG_W-1:0]   w_resp;
  logic [FRAME_W-1:0] w_tx_frame;

  assign w_resp = {r_pulses, HDR_DONE};

  for (genvar gi = 0; gi < RESP_BYTES; gi++) begin : g_frame
    assign w_tx_frame[gi*FRAME_BITS +: FRAME_BITS] = {1'b1, w_resp[gi*8 +: 8], 1'b0};
  end

  logic [FRAME_W-1:0] r_tx_shift;
  logic [5:0]         r_tx_bits_left;
  logic [CNT_W-1:0]   r_tx_cnt;
  logic               r_tx_pin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_pin       <= 1'b1;
      r_tx_busy      <= 1'b0;
      r_tx_shift     <= '1;
      r_tx_bits_left <= '0;
      r_tx_cnt       <= '0;
    end else if (!r_tx_busy) begin
      if (r_state == ST_REPORT) begin
        r_tx_pin       <= w_tx_frame[0];
        r_tx_shift     <= {1'b1, w_tx_frame[FRAME_W-1:1]};
        r_tx_bits_left <= 6'(FRAME_W - 1);
        r_tx_cnt       <= BIT_LAST;
        r_tx_busy      <= 1'b1;
      end
    end else if (r_tx_cnt == '0) begin
      if (r_tx_bits_left == '0) begin
        r_tx_busy <= 1'b0;
        r_tx_pin  <= 1'b1;
      end else begin
        r_tx_pin       <= r_tx_shift[0];
        r_tx_shift     <= {1'b1, r_tx_shift[FRAME_W-1:1]};
        r_tx_bits_left <= r_tx_bits_left - 6'd1;
        r_tx_cnt       <= BIT_LAST;
      end
    end else begin
      r_tx_cnt <= r_tx_cnt - 1'b1;
    end
  end

  assign uart_tx_pin = r_tx_pin;
  assign led0        = r_led0;
  assign led1        = r_led1;
endmodule

// File: tb/tb_test_harness.sv
// Self-checking bench for test_harness. Commands are sent as real UART
// frames; led0/led1 are measured as pulse/gap lengths and the response is
// decoded from uart_tx_pin. Expectations come from a parameter model kept
// in the bench (pulse count, effective width/gap, DONE packet contents).
module tb_test_harness;
  localparam int CLK_RATE = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_RATE / BAUD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx_pin = 1'b1;
  logic uart_tx_pin, led0, led1;

  always #5 clk = ~clk;

  test_harness #(.CLK_RATE(CLK_RATE), .BAUD(BAUD)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx_pin(uart_rx_pin),
    .uart_tx_pin(uart_tx_pin),
    .led0       (led0),
    .led1       (led1)
  );

  // Decoded response bytes travel from the line monitor to the collector.
  test_harness_if mon_if ();

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // ---------------- monitors ----------------
  bit         mon_en = 1'b0;
  int         rises = 0, led1_cycles = 0, stray = 0, resp_ferr = 0;
  int         q_high[$];
  int         q_low[$];
  logic [7:0] q_resp[$];

  initial begin : led_monitor
    bit prev0;
    bit in_gap;
    int high_len;
    int low_len;
    prev0 = 0; in_gap = 0; high_len = 0; low_len = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (led1) led1_cycles++;
        if (led0 && !led1) stray++;
        if (led0) begin
          if (!prev0) begin
            rises++;
            if (in_gap) q_low.push_back(low_len);
            in_gap = 0;
            high_len = 0;
          end
          high_len++;
        end else begin
          if (prev0) begin
            q_high.push_back(high_len);
            in_gap = 1;
            low_len = 0;
          end
          if (in_gap) begin
            if (led1) low_len++;
            else begin
              q_low.push_back(low_len);
              in_gap = 0;
            end
          end
        end
        prev0 = led0;
      end
    end
  end

  initial begin : tx_monitor
    logic [7:0] b;
    mon_if.byte_valid = 1'b0;
    mon_if.byte_data  = 8'h00;
    mon_if.frame_err  = 1'b0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (uart_tx_pin == 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        if (uart_tx_pin == 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = uart_tx_pin;
          end
          repeat (CPB) @(negedge clk);
          mon_if.frame_err  = !uart_tx_pin;
          mon_if.byte_data  = b;
          mon_if.byte_valid = 1'b1;
          @(negedge clk);
          mon_if.byte_valid = 1'b0;
          mon_if.frame_err  = 1'b0;
        end
      end
    end
  end

  initial begin : resp_collector
    forever begin
      @(posedge clk);
      if (mon_if.byte_valid) begin
        q_resp.push_back(mon_if.byte_data);
        if (mon_if.frame_err) resp_ferr++;
        $display("rx response byte %02h", mon_if.byte_data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx_pin = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx_pin = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx_pin = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx_pin = 1'b1;
    if (!stop_ok) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_packet(input logic [7:0] hdr, input logic [31:0] pay);
    logic [39:0] msg;
    msg = {pay, hdr};
    for (int i = 0; i < 5; i++) send_byte(msg[8*i +: 8], 1'b1);
    repeat (4) @(negedge clk);
    $display("sent packet hdr=%02h payload=%08h", hdr, pay);
  endtask

  // Reference model: the parameter registers as the bench believes them.
  int m_nums = 0, m_mode = 0, m_w = 1, m_g = 1;

  task automatic load_params(input int nums, input int mode, input int w, input int g);
    logic [6:0] junk;
    logic [7:0] b_nums, b_w, b_g;
    junk = 7'($urandom);
    b_nums = 8'(nums); b_w = 8'(w); b_g = 8'(g);
    send_packet(8'h01, {b_g, b_w, junk, mode[0], b_nums});
    m_nums = nums; m_mode = mode; m_w = w; m_g = g;
  endtask

  task automatic check_resp(input int base, input int count, input string name);
    int c;
    logic [39:0] exp_msg;
    c = 0;
    while (q_resp.size() < base + 5 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    if (q_resp.size() < base + 5) begin
      check_value({name, ":resp_timeout"}, q_resp.size() - base, 5);
    end else begin
      repeat (2 * CPB) @(negedge clk);
      exp_msg = {32'(count), 8'h03};
      for (int i = 0; i < 5; i++)
        check_value($sformatf("%s:resp_byte%0d", name, i), 32'(q_resp[base + i]), 32'(exp_msg[8*i +: 8]));
      check_value({name, ":resp_len"}, q_resp.size() - base, 5);
    end
  endtask

  task automatic check_shapes(input int hb, input int lb, input int n, input int we, input int ge,
                              input string name);
    int bad_w, bad_g;
    bad_w = 0; bad_g = 0;
    for (int i = hb; i < q_high.size(); i++) if (q_high[i] != we) bad_w++;
    for (int i = lb; i < q_low.size(); i++) if (q_low[i] != ge) bad_g++;
    check_value({name, ":width_errs"}, bad_w, 0);
    check_value({name, ":gap_errs"}, bad_g, 0);
    check_value({name, ":gap_count"}, q_low.size() - lb, n);
  endtask

  // Start a run with the current model parameters (test_mode=0) and check it.
  task automatic run_and_check(input string name);
    int rb, l1, hb, lb, rs, n, we, ge;
    rb = rises; l1 = led1_cycles; hb = q_high.size(); lb = q_low.size(); rs = q_resp.size();
    send_packet(8'h02, ($urandom & 32'hFFFF_FFFE) | 32'h1);
    check_resp(rs, m_nums, name);
    n  = m_nums;
    we = (m_w == 0) ? 1 : m_w;
    ge = (m_g == 0) ? 1 : m_g;
    check_value({name, ":pulses"}, rises - rb, n);
    if (n > 0) check_value({name, ":led1_cycles"}, led1_cycles - l1, n * (we + ge));
    check_shapes(hb, lb, n, we, ge, name);
  endtask

  initial begin : main
    int rb, hb, lb, rs, n_seen;

    repeat (5) @(negedge clk);
    check_value("reset:led0", led0, 0);
    check_value("reset:led1", led1, 0);
    check_value("reset:tx_idle", uart_tx_pin, 1);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);

    // Basic five-pulse run.
    load_params(5, 0, 12, 12);
    run_and_check("basic");

    // Corrupt byte mid-packet must reset the byte counter.
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b0);
    load_params(3, 0, 4, 2);
    run_and_check("frame_err");

    // Zero pulses goes straight to the report.
    load_params(0, 0, 5, 5);
    run_and_check("zero_nums");

    // Randomised parameter sets, including zero width/gap.
    for (int k = 0; k < 6; k++) begin
      load_params($urandom_range(1, 4), 0, $urandom_range(0, 5), $urandom_range(0, 5));
      run_and_check($sformatf("rand%0d", k));
    end

    // Unknown header: nothing happens, parameters unchanged.
    rb = rises; rs = q_resp.size();
    send_packet(8'h7F, $urandom);
    repeat (300) @(negedge clk);
    check_value("hdr7f:no_resp", q_resp.size() - rs, 0);
    check_value("hdr7f:led1", led1, 0);
    check_value("hdr7f:no_pulse", rises - rb, 0);
    run_and_check("after_7f");

    // Free-running mode; a parameter load mid-run must not disturb it.
    load_params(3, 1, 1, 1);
    rb = rises; hb = q_high.size(); lb = q_low.size(); rs = q_resp.size();
    send_packet(8'h02, 32'h1);
    check_value("mode:led1_running", led1, 1);
    load_params(2, 0, 3, 2);
    send_packet(8'h02, 32'h0);
    repeat (10) @(negedge clk);
    n_seen = rises - rb;
    check_value("mode:repeats", (n_seen > 500) ? 1 : 0, 1);
    check_value("mode:led1_after_stop", led1, 0);
    check_shapes(hb, lb, n_seen, 1, 1, "mode");
    check_resp(rs, n_seen, "mode");
    run_and_check("snapshot_after_mode");

    // Reset in the middle of a run aborts it silently.
    load_params(5, 0, 200, 200);
    rb = rises; rs = q_resp.size();
    send_packet(8'h02, 32'h1);
    repeat (100) @(negedge clk);
    check_value("rst_run:led1_before", led1, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_value("rst_run:led0", led0, 0);
    check_value("rst_run:led1", led1, 0);
    check_value("rst_run:tx", uart_tx_pin, 1);
    repeat (1500) @(negedge clk);
    check_value("rst_run:no_resp", q_resp.size() - rs, 0);
    check_value("rst_run:one_pulse", rises - rb, 1);
    // Parameters return to their reset values (no_nums = 0).
    m_nums = 0; m_mode = 0; m_w = 1; m_g = 1;
    run_and_check("after_reset");

    check_value("stray_led0", stray, 0);
    check_value("resp_frame_errs", resp_ferr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/test_harness.md
TEST_HARNESS -- requirements
Module: test_harness

Interface
REQ-001 The block SHALL have parameter CLK_RATE, default 12_000_000, meaning clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning UART bit rate; CLKS_PER_BAUD = CLK_RATE/BAUD (1250).
REQ-003 The block SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port uart_rx_pin, input, 1 bit: UART receive line, asynchronous, idle high.
REQ-006 The block SHALL have port uart_tx_pin, output, 1 bit: UART transmit line, idle high.
REQ-007 The block SHALL have port led0, output, 1 bit: pulse-train output.
REQ-008 The block SHALL have port led1, output, 1 bit: high while a run is active.

Function
REQ-009 The UART format SHALL be 8N1: start 0, 8 data bits LSB first, 1 stop bit of 1.
REQ-010 uart_rx_pin SHALL pass through a 2-flop synchronizer before use.
REQ-011 The receiver SHALL detect the falling edge, re-check low at half a bit, then sample each data bit and the stop bit at bit centres.
REQ-012 A stop bit sampled 0 SHALL discard the byte and clear the packet byte counter.
REQ-013 A packet SHALL be 5 bytes (40 bits) assembled LSB byte first: msg[7:0] = header, msg[39:8] = payload.
REQ-014 Header 0x01 (MEM_PARAMS) SHALL load the parameter registers from payload: no_nums = payload[7:0], test_mode = payload[8], pulse_width = payload[23:16], pulse_gap = payload[31:24]; payload[15:9] is ignored.
REQ-015 Header 0x02 (SYS_STATUS) SHALL start a run when payload[0]=1 and the block is idle, and SHALL stop a run at the end of the current gap when payload[0]=0.
REQ-016 All other headers SHALL be ignored.
REQ-017 MEM_PARAMS received during a run SHALL update the registers, but the active run SHALL use the values captured at its start.
REQ-018 Run: led1=1 from the cycle after the command is decoded; led0 SHALL be high for pulse_width cycles, then low for pulse_gap cycles, repeated.
REQ-019 A width or gap value of 0 SHALL be treated as 1.
REQ-020 Pulse state machine SHALL have states IDLE, HIGH, GAP, REPORT; it SHALL move IDLE->HIGH on start, HIGH->GAP after width cycles, GAP->HIGH when further pulses remain, and GAP->REPORT otherwise, and REPORT SHALL return to IDLE.
REQ-021 With test_mode=0 the run SHALL end after no_nums pulses.
REQ-022 With no_nums=0 the run SHALL go straight to REPORT with count 0.
REQ-023 With test_mode=1 the run SHALL repeat until stopped.
REQ-024 At run end led1 SHALL return to 0.
REQ-025 The block SHALL transmit a 5-byte response, LSB byte first, with header 0x03 (DONE) and payload = 32-bit count of pulses emitted.
REQ-026 The response SHALL start within 2 cycles of entering REPORT, with bytes back-to-back and no idle bits between them.
REQ-027 A start command arriving while the transmitter is busy SHALL be ignored.
REQ-028 Command decode SHALL occur 1 cycle after the 5th byte's stop-bit sample.

Reset
REQ-029 On rst: uart_tx_pin=1, led0=0, led1=0, FSM=IDLE, byte counter=0, no_nums=0, test_mode=0, pulse_width=1, pulse_gap=1, and receiver/transmitter idle.
REQ-030 A reset mid-frame or mid-run SHALL abort it without emitting a response; the transmit line SHALL return high on the next cycle.

Structure
REQ-031 Package test_harness_pkg SHALL hold the message width (40), header slice, payload slice, the header codes 0x01/0x02/0x03, and the payload field positions.
REQ-032 One sub-module uart_rx (synchronizer, sampling, byte_valid strobe) SHALL be instantiated; the transmitter, assembler and FSM SHALL be inline.

Verification
REQ-033 Send MEM_PARAMS {no_nums=5, test_mode=0, width=12, gap=12}, then SYS_STATUS 1 -> five 12-cycle led0 pulses separated by 12-cycle gaps, led1 high throughout, response bytes 03 05 00 00 00.
REQ-034 Byte with stop bit 0 followed by a valid 5-byte packet -> the corrupt byte is discarded and the packet is decoded correctly.
REQ-035 no_nums=0 then run -> no led0 pulse, response 03 00 00 00 00.
REQ-036 test_mode=1 with width=1, gap=1, run, then SYS_STATUS 0 -> 1-cycle pulses every 2 cycles until stop, response count equals the pulses seen.
REQ-037 Assert rst mid-run -> led0=0, led1=0, uart_tx_pin=1, and no response.
REQ-038 Header 0x7F packet -> no state change and no transmission.
